// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, state encoding and address helpers for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int ADDRESS_LEN     = 32;
    localparam int INSTRUCTION_LEN = 32;

    localparam logic [ADDRESS_LEN-1:0] WORD_STEP = ADDRESS_LEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HAVE = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [ADDRESS_LEN-1:0] word_align(input logic [ADDRESS_LEN-1:0] addr);
        return addr & ~(ADDRESS_LEN'(3));
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the request/ready handshake to instruction
// memory and presents PC+4 / Instruction to the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [ADDRESS_LEN-1:0]     branch_addr,
    output logic                       mem_req,
    output logic [ADDRESS_LEN-1:0]     mem_addr,
    input  logic [INSTRUCTION_LEN-1:0] mem_rdata,
    input  logic                       mem_ready,
    output logic [ADDRESS_LEN-1:0]     PC,
    output logic [INSTRUCTION_LEN-1:0] Instruction,
    output logic                       fetch_valid,
    output logic                       fetch_stall
);

    fetch_state_e               state_q, state_d;
    logic [ADDRESS_LEN-1:0]     pc_q, pc_d;
    logic [ADDRESS_LEN-1:0]     req_addr_q, req_addr_d;
    logic [INSTRUCTION_LEN-1:0] inst_q, inst_d;
    logic                       mem_req_c;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= '0;
            req_addr_q <= '0;
            inst_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        inst_d      = inst_q;
        mem_req_c   = 1'b0;
        mem_addr    = pc_q;
        fetch_valid = 1'b0;
        Instruction = inst_q;

        unique case (state_q)
            S_REQ: begin
                mem_req_c   = 1'b1;
                fetch_valid = mem_ready;
                if (mem_ready) begin
                    Instruction = mem_rdata;
                end
                if (branch_taken) begin
                    pc_d = word_align(branch_addr);
                    // A live request cannot be withdrawn; remember it and absorb its reply.
                    if (!mem_ready) begin
                        req_addr_d = pc_q;
                        state_d    = S_DROP;
                    end
                end else if (mem_ready) begin
                    if (freeze) begin
                        inst_d  = mem_rdata;
                        state_d = S_HAVE;
                    end else begin
                        pc_d = pc_q + WORD_STEP;
                    end
                end
            end

            S_HAVE: begin
                fetch_valid = 1'b1;
                if (branch_taken) begin
                    pc_d    = word_align(branch_addr);
                    state_d = S_REQ;
                end else if (!freeze) begin
                    pc_d    = pc_q + WORD_STEP;
                    state_d = S_REQ;
                end
            end

            S_DROP: begin
                mem_req_c = 1'b1;
                mem_addr  = req_addr_q;
                if (branch_taken) begin
                    pc_d = word_align(branch_addr);
                end
                if (mem_ready) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign mem_req     = mem_req_c & ~rst;
    assign PC          = pc_q + WORD_STEP;
    assign fetch_stall = ~fetch_valid;

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the ARM pipeline. It owns the program counter, fetches instruction words from a wait-state instruction memory over a request/ready handshake, and presents `PC` (fetch address + 4) and `Instruction` to the IF/ID pipeline register. It also raises `fetch_stall` for the hazard/freeze logic when no instruction is available. Branch redirects come from the execute stage; discarding the stale instruction in the IF/ID register is that register's job (flush = `branch_taken`).

## Interface
- `ADDRESS_LEN`, 32, width of PC and memory address (from `defines.v`)
- `INSTRUCTION_LEN`, 32, width of an instruction word (from `defines.v`)

- `clk` in 1: pipeline clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `freeze` in 1: downstream hazard stall; hold current instruction and PC
- `branch_taken` in 1: redirect fetch to `branch_addr`
- `branch_addr` in ADDRESS_LEN: redirect target; bits [1:0] ignored (forced 0)
- `mem_req` out 1: instruction-memory read request
- `mem_addr` out ADDRESS_LEN: word-aligned read address
- `mem_rdata` in INSTRUCTION_LEN: read data, valid when `mem_ready`=1
- `mem_ready` in 1: memory completes the outstanding request this cycle
- `PC` out ADDRESS_LEN: address of the presented instruction + 4
- `Instruction` out INSTRUCTION_LEN: fetched instruction word
- `fetch_valid` out 1: `PC`/`Instruction` valid this cycle
- `fetch_stall` out 1: equals ~`fetch_valid`; ORed into freeze by hazard logic

## Operation
- Registers: `pc_reg` (fetch address), `req_addr` (address of abandoned request), `inst_q` (held instruction), `state`.
- `S_REQ`: `mem_req`=1, `mem_addr`=`pc_reg`.
  - `mem_ready`=1: `fetch_valid`=1, `Instruction`=`mem_rdata` (bypass). If ~`freeze`, `pc_reg`<=`pc_reg`+4 and stay. If `freeze`, `inst_q`<=`mem_rdata` and go to `S_HAVE`.
  - `mem_ready`=0: `fetch_valid`=0, stay.
- `S_HAVE`: `mem_req`=0, `fetch_valid`=1, `Instruction`=`inst_q`. If ~`freeze`, `pc_reg`<=`pc_reg`+4 and go to `S_REQ`. Otherwise hold.
- `S_DROP`: `mem_req`=1, `mem_addr`=`req_addr`, `fetch_valid`=0. On `mem_ready`, discard `mem_rdata` and go to `S_REQ`.
- Branch priority is higher than freeze and sequencing. `branch_taken` in any state sets `pc_reg`<=`branch_addr`&~3.
  - In `S_REQ` with `mem_ready`=0: `req_addr`<=`pc_reg` and go to `S_DROP`. The request is never retracted mid-handshake.
  - In `S_REQ` with `mem_ready`=1: data is ignored; stay in `S_REQ`.
  - In `S_HAVE`: go to `S_REQ`.
  - In `S_DROP`: retarget `pc_reg`. Exit to `S_REQ` on `mem_ready` as usual.
- `PC` = `pc_reg`+4 in every state. Address arithmetic wraps modulo 2^ADDRESS_LEN (0xFFFFFFFC + 4 = 0).

## Timing
- Reset (async) values: `state`=`S_REQ`, `pc_reg`=0, `req_addr`=0, `inst_q`=0.
- `mem_req` is gated low while `rst`=1. After reset: `PC`=4, `fetch_valid`=0 until the first `mem_ready`.
- Zero-wait memory: one instruction per cycle. Address is presented and data returned in the same cycle. This is a combinational path from `mem_rdata`/`mem_ready` to `Instruction`/`fetch_valid`.
- N wait states: `fetch_valid` is high for 1 cycle in every N+1 cycles.
- Branch redirect: the first request to the target is issued the next cycle. If a request was pending, the target request issues the cycle after the abandoned request's `mem_ready`.
- Reset mid-handshake abandons the transaction. The memory model must tolerate a dropped request.

## Structure
- Add to `defines.v`: `ADDRESS_LEN`, `INSTRUCTION_LEN`, 2-bit state encodings `S_REQ`/`S_HAVE`/`S_DROP`.
- Single module; no sub-module needed.
- Testbench uses a separate `inst_mem_model` with programmable wait states.

## Test plan
- Reset, zero-wait memory returning `rdata`=`addr`|0xE0000000: `mem_addr` 0,4,8 on consecutive cycles; `PC` 4,8,12; `fetch_valid`=1 every cycle.
- Two wait states at address 0: `fetch_stall`=1 for 2 cycles, then `fetch_valid`=1 with `Instruction`=0xE0000000. Next `mem_addr`=4.
- Fetch at 8 with `freeze` held 3 cycles: `PC` stays 12 and `Instruction` stays word(8). `mem_req`=0 in `S_HAVE`. `mem_addr`=12 on the cycle after `freeze` drops.
- Request at 0x10 waiting, `branch_taken` to 0x43: `S_DROP`; word(0x10) is not presented (`fetch_valid`=0). Next request is at 0x40 with `PC`=0x44.
- `branch_taken` and `freeze` together in `S_HAVE`: branch wins; next `mem_addr`=`branch_addr`.
- `rst` pulsed during a wait state: `mem_req`=0 immediately. After release, `mem_addr`=0 and `PC`=4.
- `pc_reg`=0xFFFFFFFC with zero-wait memory: `PC`=0, next `mem_addr`=0.
